pc_fetch_ctrl: RTL
==================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2: cycles `flush` stays high after a redirect (legal range 1..7).
REQ-003 SHALL have port clk, in, 1: single clock, rising edge.
REQ-004 SHALL have port rst_n, in, 1: asynchronous, active-low reset.
REQ-005 SHALL have port pcjump, in, 1: taken branch/jump from the branch unit in EX.
REQ-006 SHALL have port target, in, 32: redirect address, valid when pcjump=1.
REQ-007 SHALL have port stall, in, 1: hazard stall from decode.
REQ-008 SHALL have port imem_req, out, 1: instruction memory request.
REQ-009 SHALL have port imem_addr, out, 32: request address.
REQ-010 SHALL have port imem_ack, in, 1: response valid; may assert in the same cycle as imem_req.
REQ-011 SHALL have port imem_rdata, in, 32: instruction data, valid with imem_ack.
REQ-012 SHALL have port if_valid, out, 1: IF/ID slot holds a valid instruction.
REQ-013 SHALL have port if_pc, out, 32: PC of the IF/ID instruction.
REQ-014 SHALL have port if_instr, out, 32: instruction word for IF/ID.
REQ-015 SHALL have port flush, out, 1: kill signal for IF/ID and ID/EX.
REQ-016 SHALL have port misalign, out, 1: one-cycle pulse, redirect target not word-aligned.
REQ-017 SHALL have port taken_cnt, out, 32: count of accepted redirects.

Function
REQ-018 SHALL implement states IDLE, FETCH, DRAIN, FLUSH; IDLE->FETCH unconditionally one cycle after reset release.
REQ-019 In FETCH, SHALL drive imem_req=1 with imem_addr=pc, holding both stable until imem_ack.
REQ-020 On imem_ack with stall=0 and pcjump=0, SHALL register if_valid=1, if_pc=pc, if_instr=imem_rdata, and set pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
REQ-021 While stall=1, SHALL freeze pc and if_valid/if_pc/if_instr, and SHALL NOT start a new request; an outstanding request continues.
REQ-022 An ack arriving while stall=1 SHALL be captured in a one-entry hold buffer and presented on if_* the cycle after stall drops; pc advances then.
REQ-023 pcjump=1 in FETCH SHALL take priority over stall and ack: pc<=target with bits [1:0] forced to 0, flush=1 that cycle, if_valid<=0, hold buffer cleared, taken_cnt incremented.
REQ-024 If the redirect cycle has an unacked request, SHALL enter DRAIN, hold the old imem_addr with imem_req=1 until ack, and discard that data; then enter FLUSH.
REQ-025 Otherwise the redirect SHALL enter FLUSH directly; an ack in the redirect cycle SHALL be discarded.
REQ-026 In FLUSH, SHALL hold flush=1 and imem_req=0 for FLUSH_CYCLES total cycles, counting the redirect cycle, then return to FETCH at the new pc.
REQ-027 SHALL ignore pcjump in DRAIN and FLUSH, because it comes from wrong-path, flushed instructions.
REQ-028 SHALL assert misalign for one cycle when an accepted redirect has target[1:0]!=0.
REQ-029 taken_cnt SHALL saturate at 32'hFFFF_FFFF.
REQ-030 Redirect latency: the first imem_req to target SHALL occur FLUSH_CYCLES cycles after the pcjump cycle (no DRAIN).

Reset
REQ-031 rst_n=0 SHALL asynchronously force state=IDLE, pc=RESET_PC, and imem_req, if_valid, flush, misalign=0.
REQ-032 rst_n=0 SHALL asynchronously force if_pc, if_instr, imem_addr, taken_cnt and the hold buffer to 0.
REQ-033 Reset asserted mid-DRAIN or mid-FLUSH SHALL abandon the sequence; the first request after release SHALL go to RESET_PC.

Structure
REQ-034 State encoding, the instruction-width constant (32) and the PC increment (4) SHALL live in the shared cpu package.
REQ-035 The hold buffer SHALL be sub-module fetch_hold_buf (1-entry valid/pc/instr register).

Verification
REQ-036 Reset release, RESET_PC=0x100, ack same cycle -> requests 0x100, 0x104, 0x108 on consecutive cycles; if_pc follows one cycle later.
REQ-037 pcjump=1, target=0x200, no outstanding request, FLUSH_CYCLES=2 -> flush high 2 cycles, next imem_addr=0x200, taken_cnt=1.
REQ-038 pcjump while request to 0x10C is unacked, ack after 3 cycles -> DRAIN holds 0x10C, its data is never on if_instr, then FLUSH, then fetch at target.
REQ-039 stall=1 for 4 cycles with ack during the stall -> if_* frozen, instr shown the cycle after stall drops, no duplicate or lost instruction.
REQ-040 target=0x203 -> misalign pulses 1 cycle, imem_addr=0x200; pc=0xFFFF_FFFC followed by an ack -> next address 0x0.
REQ-041 rst_n low mid-FLUSH -> all outputs 0 immediately; after release the first request is to RESET_PC.

Source files
------------

// File: rtl/pc_fetch_ctrl_pkg.sv
// rtl/pc_fetch_ctrl_pkg.sv - shared fetch-stage types and constants
package pc_fetch_ctrl_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - instruction memory request/response bundle
interface pc_fetch_ctrl_if;
  import pc_fetch_ctrl_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/pc_fetch_ctrl_hold_buf.sv
// rtl/pc_fetch_ctrl_hold_buf.sv - one-entry buffer for an ack that lands during a stall
module fetch_hold_buf
  import pc_fetch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            clear_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic            valid_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instr_o
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - PC sequencing, redirect/drain/flush and IF/ID register
module pc_fetch_ctrl
  import pc_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pcjump,
  input  logic [XLEN-1:0] target,
  input  logic            stall,
  pc_fetch_ctrl_if.master imem,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            flush,
  output logic            misalign,
  output logic [XLEN-1:0] taken_cnt
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            outst_q, outst_d;
  logic [XLEN-1:0] drain_addr_q, drain_addr_d;
  logic [2:0]      flush_cnt_q, flush_cnt_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic [XLEN-1:0] taken_cnt_q, taken_cnt_d;

  logic            req, hold_load, hold_clear, hold_valid;
  logic [XLEN-1:0] addr, hold_pc, hold_instr;

  fetch_hold_buf u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .pc_i    (pc_q),
    .instr_i (imem.imem_rdata),
    .valid_o (hold_valid),
    .pc_o    (hold_pc),
    .instr_o (hold_instr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      outst_q      <= 1'b0;
      drain_addr_q <= '0;
      flush_cnt_q  <= '0;
      if_valid_q   <= 1'b0;
      if_pc_q      <= '0;
      if_instr_q   <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      outst_q      <= outst_d;
      drain_addr_q <= drain_addr_d;
      flush_cnt_q  <= flush_cnt_d;
      if_valid_q   <= if_valid_d;
      if_pc_q      <= if_pc_d;
      if_instr_q   <= if_instr_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    outst_d      = outst_q;
    drain_addr_d = drain_addr_q;
    flush_cnt_d  = flush_cnt_q;
    if_valid_d   = if_valid_q;
    if_pc_d      = if_pc_q;
    if_instr_d   = if_instr_q;
    taken_cnt_d  = taken_cnt_q;
    req          = 1'b0;
    addr         = '0;
    flush        = 1'b0;
    misalign     = 1'b0;
    hold_load    = 1'b0;
    hold_clear   = 1'b0;

    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;

      ST_FETCH: begin
        // A redirect cycle never launches a fresh request; only an in-flight one stays up.
        req  = outst_q || (!stall && !hold_valid && !pcjump);
        addr = req ? pc_q : '0;
        if (pcjump) begin
          pc_d        = {target[XLEN-1:2], 2'b00};
          flush       = 1'b1;
          misalign    = |target[1:0];
          if_valid_d  = 1'b0;
          hold_clear  = 1'b1;
          outst_d     = 1'b0;
          if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + 1'b1;
          if (outst_q && !imem.imem_ack) begin
            state_d      = ST_DRAIN;
            drain_addr_d = pc_q;
          end else if (FLUSH_CYCLES > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = 3'(FLUSH_CYCLES - 2);
          end
        end else if (stall) begin
          outst_d   = req && !imem.imem_ack;
          hold_load = req && imem.imem_ack;
        end else begin
          outst_d = req && !imem.imem_ack;
          if (hold_valid) begin
            if_valid_d = 1'b1;
            if_pc_d    = hold_pc;
            if_instr_d = hold_instr;
            pc_d       = pc_q + PC_INC;
            hold_clear = 1'b1;
          end else if (req && imem.imem_ack) begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem.imem_rdata;
            pc_d       = pc_q + PC_INC;
          end else begin
            if_valid_d = 1'b0;
          end
        end
      end

      ST_DRAIN: begin
        req   = 1'b1;
        addr  = drain_addr_q;
        flush = 1'b1;
        if (imem.imem_ack) begin
          if (FLUSH_CYCLES > 1) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = 3'(FLUSH_CYCLES - 2);
          end else begin
            state_d = ST_FETCH;
          end
        end
      end

      ST_FLUSH: begin
        flush = 1'b1;
        if (flush_cnt_q == 3'd0) state_d = ST_FETCH;
        else flush_cnt_d = flush_cnt_q - 3'd1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_instr       = if_instr_q;
  assign taken_cnt      = taken_cnt_q;

endmodule
